// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: req/ready handshake with pipeline freeze.
// Optional request timeout and sticky abort flag when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hFFFF_FFFF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_en_in,
  input  logic              MEM_W_en_in,
  input  logic [ADDR_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] Val_Rm_in,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              freeze,
  output logic [DATA_W-1:0] Mem_read_value,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              state, state_nxt;
  logic                access;
  logic                req_nxt, we_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt, rdv_nxt;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             terr, terr_nxt;
  assign timeout_err = terr;
`else
  assign timeout_err = 1'b0;
  // Timeout configuration is meaningless without the timeout feature.
  logic unused_cfg;
  assign unused_cfg = ^{ERR_DATA, 32'(TIMEOUT)};
`endif

  assign access = MEM_R_en_in | MEM_W_en_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state, freeze and next values of the registered memory-side outputs.
  always_comb begin
    state_nxt = state;
    req_nxt   = mem_req;
    we_nxt    = mem_we;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    rdv_nxt   = Mem_read_value;
    freeze    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_nxt   = cnt;
    terr_nxt  = terr;
`endif
    case (state)
      IDLE: begin
        if (access) begin
          freeze    = 1'b1;
          addr_nxt  = ALU_result_in;
          wdata_nxt = Val_Rm_in;
          we_nxt    = MEM_W_en_in;
          req_nxt   = 1'b1;
          state_nxt = REQ;
`ifdef MEM_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end
      REQ: begin
        freeze = 1'b1;
        if (mem_ready) begin
          req_nxt   = 1'b0;
          if (!mem_we) rdv_nxt = mem_rdata;
          state_nxt = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          req_nxt   = 1'b0;
          terr_nxt  = 1'b1;
          if (!mem_we) rdv_nxt = ERR_DATA;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      Mem_read_value <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt            <= '0;
      terr           <= 1'b0;
`endif
    end else begin
      mem_req        <= req_nxt;
      mem_we         <= we_nxt;
      mem_addr       <= addr_nxt;
      mem_wdata      <= wdata_nxt;
      Mem_read_value <= rdv_nxt;
`ifdef MEM_TIMEOUT_EN
      cnt            <= cnt_nxt;
      terr           <= terr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed table, reset/timeout sequences,
// and randomized accesses against a transaction-level model.
module tb_mem_access_ctrl;

  localparam int unsigned TIMEOUT_B = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_en_in, MEM_W_en_in, mem_ready;
  logic [31:0] ALU_result_in, Val_Rm_in, mem_rdata;
  logic        mem_req, mem_we, freeze, timeout_err;
  logic [31:0] mem_addr, mem_wdata, Mem_read_value;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_rdv;
  bit          m_terr;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TIMEOUT_B), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst),
    .MEM_R_en_in(MEM_R_en_in), .MEM_W_en_in(MEM_W_en_in),
    .ALU_result_in(ALU_result_in), .Val_Rm_in(Val_Rm_in),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .freeze(freeze), .Mem_read_value(Mem_read_value), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
    logic [31:0] rdata;
    bit          exp_we;
    logic [31:0] exp_rdv;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge after DONE.
  task automatic run_access(input bit r, input bit w, input logic [31:0] addr, input logic [31:0] data,
                            input int waits, input logic [31:0] rdata);
    bit abort;
    int nreq;
    abort = TO_EN && (waits >= int'(TIMEOUT_B));
    nreq  = abort ? int'(TIMEOUT_B) : waits + 1;
    MEM_R_en_in = r; MEM_W_en_in = w; ALU_result_in = addr; Val_Rm_in = data;
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    #1;
    chk("idle_freeze", 32'(freeze), 32'd1);
    chk("idle_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    for (int k = 1; k <= nreq; k++) begin
      ALU_result_in = $urandom; Val_Rm_in = $urandom;
      mem_ready = (!abort && k == nreq);
      mem_rdata = (k == nreq) ? rdata : $urandom;
      #1;
      chk("req_freeze", 32'(freeze), 32'd1);
      chk("req_req", 32'(mem_req), 32'd1);
      chk("req_we", 32'(mem_we), 32'(w));
      chk("req_addr", mem_addr, addr);
      chk("req_wdata", mem_wdata, data);
      chk("req_rdv", Mem_read_value, m_rdv);
      @(negedge clk);
    end
    if (abort) m_terr = 1'b1;
    if (r && !w) m_rdv = abort ? 32'hFFFF_FFFF : rdata;
    MEM_R_en_in = 1'($urandom); MEM_W_en_in = 1'($urandom);
    ALU_result_in = $urandom; Val_Rm_in = $urandom;
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    #1;
    chk("done_freeze", 32'(freeze), 32'd0);
    chk("done_req", 32'(mem_req), 32'd0);
    chk("done_rdv", Mem_read_value, m_rdv);
    chk("done_terr", 32'(timeout_err), 32'(m_terr));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      MEM_R_en_in = 1'b0; MEM_W_en_in = 1'b0;
      mem_ready = 1'($urandom); mem_rdata = $urandom;
      #1;
      chk("idle_nofreeze", 32'(freeze), 32'd0);
      chk("idle_noreq", 32'(mem_req), 32'd0);
      chk("idle_rdv", Mem_read_value, m_rdv);
      chk("idle_terr", 32'(timeout_err), 32'(m_terr));
      @(negedge clk);
    end
  endtask

  // Asynchronous reset asserted mid-REQ, released on a negedge.
  task automatic reset_mid_req();
    MEM_R_en_in = 1'b1; MEM_W_en_in = 1'b0; ALU_result_in = 32'h200; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0; MEM_R_en_in = 1'b0;
    #1;
    m_rdv = 32'h0; m_terr = 1'b0;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_rdv", Mem_read_value, 32'h0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h100, 32'h0,         0, 32'h1234_5678, 1'b0, 32'h1234_5678};
    tbl[1] = '{1'b0, 1'b1, 32'h40,  32'hCAFE_F00D, 5, 32'h0,         1'b1, 32'h1234_5678};
    tbl[2] = '{1'b1, 1'b0, 32'h80,  32'h0,         0, 32'hA5A5_0001, 1'b0, 32'hA5A5_0001};
    tbl[3] = '{1'b0, 1'b1, 32'h84,  32'h0BAD_BEEF, 0, 32'h0,         1'b1, 32'hA5A5_0001};
    tbl[4] = '{1'b1, 1'b1, 32'h8,   32'h7777_0000, 1, 32'h5555_5555, 1'b1, 32'hA5A5_0001};

    rst = 1'b0;
    MEM_R_en_in = 1'b0; MEM_W_en_in = 1'b0; mem_ready = 1'b0;
    ALU_result_in = '0; Val_Rm_in = '0; mem_rdata = '0;
    m_rdv = 32'h0; m_terr = 1'b0;
    #3;
    chk("por_req", 32'(mem_req), 32'd0);
    chk("por_we", 32'(mem_we), 32'd0);
    chk("por_addr", mem_addr, 32'h0);
    chk("por_wdata", mem_wdata, 32'h0);
    chk("por_rdv", Mem_read_value, 32'h0);
    chk("por_terr", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);

    // Directed table; entries 2 and 3 run back to back with only DONE between them.
    for (int i = 0; i < 5; i++) begin
      run_access(tbl[i].r, tbl[i].w, tbl[i].addr, tbl[i].data, tbl[i].waits, tbl[i].rdata);
      chk("tbl_we", 32'(mem_we), 32'(tbl[i].exp_we));
      chk("tbl_rdv", Mem_read_value, tbl[i].exp_rdv);
      if (i != 2) idle(1);
    end

    reset_mid_req();

    if (TO_EN) begin
      reset_mid_req();
      run_access(1'b1, 1'b0, 32'h300, 32'h0, 1000, 32'h0);
      chk("to_err_set", 32'(timeout_err), 32'd1);
      chk("to_err_data", Mem_read_value, 32'hFFFF_FFFF);
      idle(3);
      chk("to_err_sticky", 32'(timeout_err), 32'd1);
      reset_mid_req();
      run_access(1'b1, 1'b0, 32'h304, 32'h0, int'(TIMEOUT_B) - 1, 32'h0000_BEEF);
      chk("to_last_ready_err", 32'(timeout_err), 32'd0);
      chk("to_last_ready_rdv", Mem_read_value, 32'h0000_BEEF);
    end

    // Randomized accesses with random wait counts and idle gaps.
    for (int n = 0; n < 250; n++) begin
      bit r, w;
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      r = 1'($urandom); w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      run_access(r, w, $urandom, $urandom, int'($urandom_range(0, 6)), $urandom);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
